spram_access_ctrl: RTL and testbench
====================================

# spram_access_ctrl

Request front-end for the 8-bit single-port RAM. Accepts read/write requests on a valid/ready port, queues them in a small in-order FIFO, and drives the RAM's address, data_in, write_enable and read_enable pins one operation at a time. It captures data_out for reads and returns it on a valid/ready response port, so the RAM never sees a conflicting or back-to-back read it cannot serve.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- DEPTH, 4, request FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept (= !full)
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  read data
- rsp_addr  out  ADDR_W  address the read data came from
- address  out  ADDR_W  to RAM
- data_in  out  DATA_W  to RAM
- write_enable  out  1  to RAM
- read_enable  out  1  to RAM
- data_out  in  DATA_W  from RAM; valid the cycle after read_enable is sampled

## Operation
- FIFO: push on req_valid && req_ready; pop only by FSM. Simultaneous push and pop when not full keeps count unchanged. When full, req_ready = 0 even if a pop occurs in the same cycle.
- FSM states: IDLE, WR, RD, CAP, RESP.
  - IDLE: FIFO non-empty → pop, register RAM outputs → WR or RD. Otherwise stay in IDLE.
  - WR: write_enable = 1 for exactly one cycle. Next edge: pop and issue the next request if the FIFO is non-empty, else go to IDLE.
  - RD: read_enable = 1 for one cycle → CAP.
  - CAP: latch data_out and the issued address into rsp_data/rsp_addr, set rsp_valid → RESP.
  - RESP: hold rsp_valid/rsp_data stable until rsp_ready. On the handshake edge: clear rsp_valid, and pop and issue the next request if the FIFO is non-empty, else go to IDLE.
- write_enable and read_enable are never both 1. Both are 0 in IDLE, CAP and RESP.
- Strictly in-order: a read following a write to the same address returns the new data.
- address and data_in hold their last issued value when idle.
- Addresses wrap naturally; no range check.

## Timing
- All outputs are registered. Reset values: req_ready 0 during reset and 1 after; rsp_valid 0; rsp_data 0; rsp_addr 0; address 0; data_in 0; write_enable 0; read_enable 0; FSM IDLE; FIFO empty.
- Request accepted at edge E0 with the FIFO empty and the FSM in IDLE: enables are high between E1 and E2, and the RAM samples at E2.
- Read latency: accept edge E0 → rsp_valid high after E3, so 3 cycles minimum.
- Throughput: back-to-back writes issue one per cycle. A read occupies at least 3 cycles (RD, CAP, RESP) plus any rsp_ready stall.
- Reset asserted mid-operation: queued requests and any pending response are discarded, and the enables drop low asynchronously. No RAM write completes unless it was sampled before reset rose.

## Configuration
- SPRAM_CTRL_STATS_EN defined: adds outputs wr_count[15:0] and rd_count[15:0]. They increment on each WR and RD state entry, saturate at 0xFFFF, and reset to 0.
- Without the macro: no counter ports or logic. Behaviour is otherwise identical.

## Test plan
- Reset: assert reset mid-read with 3 requests queued → all outputs are at reset values immediately, and after release req_ready = 1 with no response produced.
- Write then read: write 0x5A to 0x10, then read 0x10 back-to-back → one write_enable pulse at 0x10/0x5A; rsp_valid with rsp_data 0x5A, rsp_addr 0x10.
- Fill FIFO: hold rsp_ready = 0 and push 1 read plus 4 writes → req_ready drops after DEPTH entries are buffered, and rsp_valid holds its data stable for 10 cycles. Release rsp_ready → queued writes drain at one per cycle.
- Enable exclusivity: random mix of 200 reads and writes → write_enable & read_enable is never 1, and every read returns the last value written to its address.
- Address wrap: write 0xFF→0xA5 and 0x00→0x3C, then read both → responses 0xA5 then 0x3C in order.
- SPRAM_CTRL_STATS_EN: 5 writes and 3 reads → wr_count = 5, rd_count = 3. Preloading the counters near 0xFFFF shows saturation at 0xFFFF.

Source files
------------

// File: rtl/spram_access_ctrl.sv
// spram_access_ctrl: request front-end for an 8-bit single-port RAM.
// Buffers read/write requests in a small in-order FIFO and issues them to the
// RAM one at a time, returning read data on a valid/ready response port.
// Optional feature macro: SPRAM_CTRL_STATS_EN adds saturating wr_count/rd_count.
module spram_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              write_enable,
    output logic              read_enable,
    input  logic [DATA_W-1:0] data_out
`ifdef SPRAM_CTRL_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, RESP} state_t;

    state_t               state;
    state_t               state_next;

    logic [ENTRY_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     count_next;
    logic                 fifo_empty;
    logic                 push;
    logic                 issue;

    logic                 head_write;
    logic [ADDR_W-1:0]    head_addr;
    logic [DATA_W-1:0]    head_wdata;

    logic                 we_next;
    logic                 re_next;
    logic [ADDR_W-1:0]    address_next;
    logic [DATA_W-1:0]    data_in_next;
    logic                 rsp_valid_next;
    logic [DATA_W-1:0]    rsp_data_next;
    logic [ADDR_W-1:0]    rsp_addr_next;

    assign push       = req_valid && req_ready;
    assign fifo_empty = (fifo_count == '0);
    assign head_write = fifo_mem[rd_ptr][ENTRY_W-1];
    assign head_addr  = fifo_mem[rd_ptr][ADDR_W+DATA_W-1:DATA_W];
    assign head_wdata = fifo_mem[rd_ptr][DATA_W-1:0];
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(issue);

    // FIFO payload storage; entries are only meaningful while counted, so no reset
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata};
        end
    end

    // FIFO pointers, occupancy and the registered ready (low in reset, low when full)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            req_ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_next;
            req_ready  <= (count_next != CNT_W'(DEPTH));
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; issue marks the edge where the FIFO head is popped and sent to the RAM
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE, WR: begin
                if (!fifo_empty) begin
                    issue      = 1'b1;
                    state_next = head_write ? WR : RD;
                end else begin
                    state_next = IDLE;
                end
            end
            RD: begin
                state_next = CAP;
            end
            CAP: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        issue      = 1'b1;
                        state_next = head_write ? WR : RD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs; address/data_in hold unless a new op issues
    always_comb begin
        we_next        = issue && head_write;
        re_next        = issue && !head_write;
        address_next   = issue ? head_addr : address;
        data_in_next   = (issue && head_write) ? head_wdata : data_in;
        rsp_valid_next = (state == CAP) || ((state == RESP) && !rsp_ready);
        rsp_data_next  = (state == CAP) ? data_out : rsp_data;
        rsp_addr_next  = (state == CAP) ? address : rsp_addr;
    end

    // Output registers; async reset drops the RAM enables immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
            address      <= '0;
            data_in      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_addr     <= '0;
        end else begin
            write_enable <= we_next;
            read_enable  <= re_next;
            address      <= address_next;
            data_in      <= data_in_next;
            rsp_valid    <= rsp_valid_next;
            rsp_data     <= rsp_data_next;
            rsp_addr     <= rsp_addr_next;
        end
    end

`ifdef SPRAM_CTRL_STATS_EN
    // Saturating counters of WR and RD state entries
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (we_next && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (re_next && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spram_access_ctrl.sv
// tb_spram_access_ctrl: table-driven and scoreboarded bench for spram_access_ctrl.
// Includes a behavioural single-port RAM; reads/writes are predicted at request
// acceptance and compared when the DUT drives the RAM or returns a response.
module tb_spram_access_ctrl;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } pair_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] expData;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [7:0] rsp_addr;
    logic [7:0] address;
    logic [7:0] data_in;
    logic       write_enable;
    logic       read_enable;
    logic [7:0] data_out = 8'h00;
`ifdef SPRAM_CTRL_STATS_EN
    logic [15:0] wr_count;
    logic [15:0] rd_count;
`endif

    logic [7:0] ramMem [256] = '{default: 8'h00};
    logic [7:0] refMem [256] = '{default: 8'h00};
    logic [7:0] savedMem [256];

    pair_t rq[$];
    pair_t wq[$];

    int  vecCount  = 0;
    int  missCount = 0;
    logic randReady = 1'b0;

    vec_t vecs [9];

    spram_access_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_addr     (rsp_addr),
        .address      (address),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out)
`ifdef SPRAM_CTRL_STATS_EN
        ,
        .wr_count     (wr_count),
        .rd_count     (rd_count)
`endif
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Behavioural single-port RAM: read data appears the cycle after read_enable is sampled
    always @(posedge clock) begin
        if (write_enable) begin
            ramMem[address] <= data_in;
        end
        if (read_enable) begin
            data_out <= ramMem[address];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor sampled on the falling edge, away from the active edge
    always @(negedge clock) begin
        pair_t p;
        if (!reset) begin
            checkOutput("enable exclusivity", {31'd0, write_enable && read_enable}, 32'd0);
            if (write_enable) begin
                if (wq.size() == 0) begin
                    checkOutput("unexpected write", 32'd1, 32'd0);
                end else begin
                    p = wq.pop_front();
                    checkOutput("write address", {24'd0, address}, {24'd0, p.addr});
                    checkOutput("write data", {24'd0, data_in}, {24'd0, p.data});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    checkOutput("unexpected response", 32'd1, 32'd0);
                end else begin
                    p = rq.pop_front();
                    checkOutput("rsp_addr", {24'd0, rsp_addr}, {24'd0, p.addr});
                    checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, p.data});
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] expData);
        int   waitCycles = 0;
        logic accepted   = 1'b0;
        pair_t p;
        if (randReady) rsp_ready = ($urandom_range(0, 3) != 0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (!accepted && waitCycles < 200) begin
            @(negedge clock);
            accepted = req_ready;
            @(posedge clock);
            #1;
            waitCycles++;
            if (!accepted && randReady) rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = 1'b0;
        if (!accepted) begin
            checkOutput("request accept timeout", 32'd0, 32'd1);
        end else begin
            p.addr = addr;
            if (wr) begin
                p.data = wdata;
                wq.push_back(p);
                refMem[addr] = wdata;
            end else begin
                p.data = expData;
                rq.push_back(p);
            end
        end
    endtask

    task automatic drainQueues(input int limit);
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < limit) begin
            @(posedge clock);
            n++;
        end
        #1;
        checkOutput("drain pending", rq.size() + wq.size(), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("reset req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_data", {24'd0, rsp_data}, 32'd0);
        checkOutput("reset rsp_addr", {24'd0, rsp_addr}, 32'd0);
        checkOutput("reset address", {24'd0, address}, 32'd0);
        checkOutput("reset data_in", {24'd0, data_in}, 32'd0);
        checkOutput("reset write_enable", {31'd0, write_enable}, 32'd0);
        checkOutput("reset read_enable", {31'd0, read_enable}, 32'd0);
    endtask

    // Main test sequence
    initial begin
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;

        vecs[0] = '{1'b1, 8'h10, 8'h5A, 8'h00};
        vecs[1] = '{1'b0, 8'h10, 8'h00, 8'h5A};
        vecs[2] = '{1'b1, 8'hFF, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 8'h3C, 8'h00};
        vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'hA5};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 8'h3C};
        vecs[6] = '{1'b1, 8'h33, 8'h11, 8'h00};
        vecs[7] = '{1'b1, 8'h33, 8'h22, 8'h00};
        vecs[8] = '{1'b0, 8'h33, 8'h00, 8'h22};

        // Power-on reset
        #1 reset = 1'b1;
        #2;
        checkResetOutputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("req_ready after reset", {31'd0, req_ready}, 32'd1);

        // Table-driven back-to-back requests
        rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].expData);
        end
        drainQueues(100);

        // Read latency: accept at E0, enable between E1 and E2, rsp_valid after E3
        applyStimulus(1'b0, 8'h10, 8'h00, 8'h5A);
        @(posedge clock); #1;
        checkOutput("latency E1 read_enable", {31'd0, read_enable}, 32'd1);
        checkOutput("latency E1 address", {24'd0, address}, 32'h10);
        @(posedge clock); #1;
        checkOutput("latency E2 read_enable", {31'd0, read_enable}, 32'd0);
        checkOutput("latency E2 rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clock); #1;
        checkOutput("latency E3 rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("latency E3 rsp_data", {24'd0, rsp_data}, 32'h5A);
        drainQueues(50);

        // Fill the FIFO behind a stalled response
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 8'h10, 8'h00, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h40 + 8'(i), 8'h80 + 8'(i), 8'h00);
        end
        checkOutput("full req_ready", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            checkOutput("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("stall rsp_data", {24'd0, rsp_data}, 32'h5A);
            checkOutput("stall req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            checkOutput("drain write_enable", {31'd0, write_enable}, 32'd1);
            checkOutput("drain address", {24'd0, address}, 32'h40 + i);
        end
        @(posedge clock); #1;
        checkOutput("drain done write_enable", {31'd0, write_enable}, 32'd0);
        drainQueues(50);

        // Random mix with random response back-pressure
        randReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = 8'h60 + 8'($urandom_range(0, 15));
            wdata = 8'($urandom_range(0, 255));
            applyStimulus(wr, addr, wdata, refMem[addr]);
        end
        randReady = 1'b0;
        rsp_ready = 1'b1;
        drainQueues(200);

        // Reset while a read is on the RAM pins with three requests still queued
        savedMem = refMem;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 8'h10, 8'h00, refMem[8'h10]);
        applyStimulus(1'b0, 8'h20, 8'h00, refMem[8'h20]);
        applyStimulus(1'b1, 8'h50, 8'hE0, 8'h00);
        applyStimulus(1'b1, 8'h51, 8'hE1, 8'h00);
        applyStimulus(1'b1, 8'h52, 8'hE2, 8'h00);
        repeat (2) @(posedge clock);
        #1 rsp_ready = 1'b1;
        @(posedge clock); #1;
        checkOutput("pre-reset read_enable", {31'd0, read_enable}, 32'd1);
        checkOutput("pre-reset address", {24'd0, address}, 32'h20);
        reset = 1'b1;
        #1;
        checkResetOutputs();
        rq.delete();
        wq.delete();
        refMem = savedMem;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        checkOutput("post-reset req_ready", {31'd0, req_ready}, 32'd1);
        repeat (10) @(posedge clock);
        #1;
        checkOutput("post-reset rsp_valid", {31'd0, rsp_valid}, 32'd0);

`ifdef SPRAM_CTRL_STATS_EN
        // Statistics counters after reset: 5 writes and 3 reads
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'h70 + 8'(i), 8'h10 + 8'(i), 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h70 + 8'(i), 8'h00, 8'h10 + 8'(i));
        end
        drainQueues(100);
        checkOutput("wr_count", {16'd0, wr_count}, 32'd5);
        checkOutput("rd_count", {16'd0, rd_count}, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
